// File: rtl/maxpool_layer_if.sv
// Pixel stream into the pooling stage and per-channel ibuf write port out of it.
interface maxpool_layer_if #(
  parameter int unsigned input_channels = 5,
  parameter int unsigned datatype_size  = 8
);
  logic                     i_we;
  logic [datatype_size-1:0] i_data [input_channels];
  logic                     o_we   [input_channels];
  logic [datatype_size-1:0] o_data [input_channels];
  logic                     o_busy;
  logic                     o_frame_done;

  modport master (
    output i_we, i_data,
    input  o_we, o_data, o_busy, o_frame_done
  );

  modport slave (
    input  i_we, i_data,
    output o_we, o_data, o_busy, o_frame_done
  );
endinterface

// File: rtl/maxpool_layer.sv
// Streaming non-overlapping max-pool: column maxima are folded per pixel, window maxima
// are folded across rows through a one-row buffer of partial window results.
module maxpool_layer #(
  parameter int unsigned input_channels = 5,
  parameter int unsigned img_width      = 28,
  parameter int unsigned pool_dim       = 2,
  parameter int unsigned datatype_size  = 8
) (
  input logic            clk,
  input logic            rst,
  maxpool_layer_if.slave bus
);
  localparam int unsigned out_width = img_width / pool_dim;
  localparam int unsigned Limit     = out_width * pool_dim;
  localparam int unsigned CntW      = (img_width > 1) ? $clog2(img_width) : 1;
  localparam int unsigned WcW       = (out_width > 1) ? $clog2(out_width) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(img_width - 1);

  typedef logic [datatype_size-1:0] pix_t;

  logic [CntW-1:0] col_q, col_d, row_q, row_d;
  logic            we_q, busy_q, done_q;
  pix_t            data_q   [input_channels];
  pix_t            colacc_q [input_channels];
  pix_t            rowbuf_q [input_channels][out_width];

  int unsigned     col_u, row_u, pc, pr;
  logic [WcW-1:0]  wc;
  logic            win_end, emit;
  pix_t            cur [input_channels];
  pix_t            win [input_channels];

  always_comb begin
    col_u   = 32'(col_q);
    row_u   = 32'(row_q);
    pc      = col_u % pool_dim;
    pr      = row_u % pool_dim;
    wc      = WcW'(col_u / pool_dim);
    // Trailing partial columns/rows never close a window.
    win_end = bus.i_we && (col_u < Limit) && (row_u < Limit) && (pc == pool_dim - 1);
    emit    = win_end && (pr == pool_dim - 1);
  end

  always_comb begin
    for (int ch = 0; ch < int'(input_channels); ch++) begin
      cur[ch] = ((pc == 0) || (bus.i_data[ch] > colacc_q[ch])) ? bus.i_data[ch] : colacc_q[ch];
      win[ch] = (rowbuf_q[ch][wc] > cur[ch]) ? rowbuf_q[ch][wc] : cur[ch];
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (bus.i_we) begin
      if (col_q == LastIdx) begin
        col_d = '0;
        row_d = (row_q == LastIdx) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int ch = 0; ch < int'(input_channels); ch++) data_q[ch] <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      we_q   <= emit;
      busy_q <= (col_d != '0) || (row_d != '0);
      done_q <= bus.i_we && (col_q == LastIdx) && (row_q == LastIdx);
      if (emit) begin
        // A single-row window has no buffered partial to fold in.
        for (int ch = 0; ch < int'(input_channels); ch++) data_q[ch] <= (pr == 0) ? cur[ch] : win[ch];
      end
    end
  end

  // Datapath storage needs no reset: every window starts with pc==0 / pr==0 overwrites.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < int'(input_channels); ch++) begin
      if (bus.i_we) colacc_q[ch] <= cur[ch];
      if (win_end && !emit) rowbuf_q[ch][wc] <= (pr == 0) ? cur[ch] : win[ch];
    end
  end

  always_comb begin
    for (int ch = 0; ch < int'(input_channels); ch++) begin
      bus.o_we[ch]   = we_q;
      bus.o_data[ch] = data_q[ch];
    end
  end

  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_maxpool_layer.sv
// Drives three pooling geometries (4/2, 5/2, 7/3) against a window-max frame model.
module tb_maxpool_layer;
  localparam int NDut = 3;
  localparam int NCh  = 2;
  localparam int IW[NDut] = '{4, 5, 7};
  localparam int PD[NDut] = '{2, 2, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tb_we   [NDut];
  logic [7:0] tb_data [NDut][NCh];
  logic       obs_we  [NDut][NCh];
  logic [7:0] obs_data[NDut][NCh];
  logic       obs_busy[NDut];
  logic       obs_done[NDut];

  maxpool_layer_if #(.input_channels(NCh), .datatype_size(8)) bus0 ();
  maxpool_layer_if #(.input_channels(NCh), .datatype_size(8)) bus1 ();
  maxpool_layer_if #(.input_channels(NCh), .datatype_size(8)) bus2 ();

  maxpool_layer #(.input_channels(NCh), .img_width(4), .pool_dim(2), .datatype_size(8))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  maxpool_layer #(.input_channels(NCh), .img_width(5), .pool_dim(2), .datatype_size(8))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  maxpool_layer #(.input_channels(NCh), .img_width(7), .pool_dim(3), .datatype_size(8))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.i_we = tb_we[0];  assign bus0.i_data = tb_data[0];
  assign bus1.i_we = tb_we[1];  assign bus1.i_data = tb_data[1];
  assign bus2.i_we = tb_we[2];  assign bus2.i_data = tb_data[2];
  assign obs_we[0] = bus0.o_we;  assign obs_data[0] = bus0.o_data;
  assign obs_we[1] = bus1.o_we;  assign obs_data[1] = bus1.o_data;
  assign obs_we[2] = bus2.o_we;  assign obs_data[2] = bus2.o_data;
  assign obs_busy[0] = bus0.o_busy;  assign obs_done[0] = bus0.o_frame_done;
  assign obs_busy[1] = bus1.o_busy;  assign obs_done[1] = bus1.o_frame_done;
  assign obs_busy[2] = bus2.o_busy;  assign obs_done[2] = bus2.o_frame_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: raw frame pixels plus position; window max recomputed from the frame.
  int pos [NDut];
  int fr  [NDut][NCh][64];
  int last[NDut][NCh];
  int cap0[$];
  int cap1[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int d, input bit we, input int v0, input int v1, input bit r);
    bit ew, efd, acc;
    int idx, row, col, iw, pd, ow, m;
    for (int k = 0; k < NDut; k++) begin
      tb_we[k] = 1'b0;
      for (int ch = 0; ch < NCh; ch++) tb_data[k][ch] = 8'($urandom);
    end
    tb_we[d]      = we;
    tb_data[d][0] = 8'(v0);
    tb_data[d][1] = 8'(v1);
    rst           = r;
    @(posedge clk);
    #1;
    for (int k = 0; k < NDut; k++) begin
      iw  = IW[k];
      pd  = PD[k];
      ow  = iw / pd;
      ew  = 1'b0;
      efd = 1'b0;
      acc = (k == d) && we && !r;
      if (r) begin
        pos[k] = 0;
        for (int ch = 0; ch < NCh; ch++) last[k][ch] = 0;
      end else if (acc) begin
        idx = pos[k];
        row = idx / iw;
        col = idx % iw;
        fr[k][0][idx] = v0 & 255;
        fr[k][1][idx] = v1 & 255;
        ew = (row < ow * pd) && (col < ow * pd) && (row % pd == pd - 1) && (col % pd == pd - 1);
        if (ew) begin
          for (int ch = 0; ch < NCh; ch++) begin
            m = 0;
            for (int y = row - pd + 1; y <= row; y++)
              for (int x = col - pd + 1; x <= col; x++)
                if (fr[k][ch][y * iw + x] > m) m = fr[k][ch][y * iw + x];
            last[k][ch] = m;
          end
        end
        efd    = (idx == iw * iw - 1);
        pos[k] = (idx + 1) % (iw * iw);
      end
      for (int ch = 0; ch < NCh; ch++) begin
        chk($sformatf("d%0d o_we[%0d]", k, ch), int'(obs_we[k][ch]), int'(ew));
        chk($sformatf("d%0d o_data[%0d]", k, ch), int'(obs_data[k][ch]), last[k][ch]);
      end
      chk($sformatf("d%0d o_busy", k), int'(obs_busy[k]), int'(pos[k] != 0));
      chk($sformatf("d%0d o_frame_done", k), int'(obs_done[k]), int'(efd));
    end
    if (obs_we[d][0]) begin
      cap0.push_back(int'(obs_data[d][0]));
      cap1.push_back(int'(obs_data[d][1]));
    end
  endtask

  task automatic run_frame(input int d, input int base, input bit rev, input bit gaps);
    int n, v;
    n = IW[d] * IW[d];
    for (int i = 0; i < n; i++) begin
      v = rev ? base + n - 1 - i : base + i;
      step(d, 1'b1, v, 255 - v, 1'b0);
      if (gaps) step(d, 1'b0, 0, 0, 1'b0);
    end
  endtask

  task automatic expect_caps(input string tag, input int e0[4], input int e1[4], input bit use1);
    chk({tag, " count"}, cap0.size(), 4);
    for (int i = 0; i < 4 && i < cap0.size(); i++) begin
      chk($sformatf("%s ch0 #%0d", tag, i), cap0[i], e0[i]);
      if (use1) chk($sformatf("%s ch1 #%0d", tag, i), cap1[i], e1[i]);
    end
    cap0.delete();
    cap1.delete();
  endtask

  initial begin
    int e_up[4]  = '{5, 7, 13, 15};
    int e_inv[4] = '{255, 253, 247, 245};
    int e_w5[4]  = '{6, 8, 16, 18};
    int e_rst[4] = '{105, 107, 113, 115};
    int e_rev[4] = '{15, 13, 7, 5};
    for (int k = 0; k < NDut; k++) begin
      tb_we[k] = 1'b0;
      for (int ch = 0; ch < NCh; ch++) tb_data[k][ch] = '0;
    end
    step(0, 1'b0, 0, 0, 1'b1);
    step(0, 1'b0, 0, 0, 1'b1);
    cap0.delete();
    cap1.delete();

    run_frame(0, 0, 1'b0, 1'b0);
    expect_caps("w4 cont", e_up, e_inv, 1'b1);
    run_frame(0, 0, 1'b0, 1'b1);
    expect_caps("w4 gaps", e_up, e_inv, 1'b1);
    run_frame(1, 0, 1'b0, 1'b0);
    expect_caps("w5 cont", e_w5, e_w5, 1'b0);

    for (int i = 0; i < 6; i++) step(0, 1'b1, 50 + i, 0, 1'b0);
    step(0, 1'b1, 99, 99, 1'b1);
    cap0.delete();
    cap1.delete();
    run_frame(0, 100, 1'b0, 1'b0);
    expect_caps("w4 after rst", e_rst, e_rst, 1'b0);

    run_frame(0, 0, 1'b0, 1'b0);
    cap0.delete();
    cap1.delete();
    run_frame(0, 0, 1'b1, 1'b0);
    expect_caps("w4 b2b rev", e_rev, e_rev, 1'b0);

    for (int d = 0; d < NDut; d++) begin
      for (int c = 0; c < 700; c++) begin
        step(d, ($urandom_range(0, 99) < 70), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), ($urandom_range(0, 299) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/maxpool_layer.md
Name: maxpool_layer

Overview:
Streaming max-pooling stage that sits directly downstream of a conv layer's activation function and upstream of the next layer's input buffers. It consumes raster-ordered pixels, one per channel per write strobe, all channels in lockstep. It emits one maximum per non-overlapping pool_dim x pool_dim window per channel. Its outputs drive the next layer's per-channel ibuf write-enable and write-data ports directly.

Parameters:
input_channels, 5, number of parallel channel lanes (shared timing)
img_width, 28, input image width and height (square, raster order)
pool_dim, 2, pool window side; stride equals pool_dim
datatype_size, 8, pixel width; unsigned compare
out_width, img_width/pool_dim (floor), output image width and height (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_we  in  1  input pixel valid; one pixel per channel is accepted per cycle when high
i_data  in  [datatype_size-1:0] x [input_channels-1:0]  input pixels, unpacked per channel
o_we  out  1 x [input_channels-1:0]  per-channel write strobe to the next ibuf; all lanes identical
o_data  out  [datatype_size-1:0] x [input_channels-1:0]  pooled pixel per channel
o_busy  out  1  high while a frame is partially received
o_frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Reset (rst=1 at a clk edge): col=0, row=0, o_we all 0, o_data all 0, o_busy=0, o_frame_done=0. Row-buffer contents are don't-care.
- Counters: col and row advance only on i_we=1. col wraps img_width-1 -> 0 and increments row. row wraps img_width-1 -> 0, which ends the frame.
- Derived indices: pc=col%pool_dim, pr=row%pool_dim, wc=col/pool_dim.
- Column accumulator (per channel):
  - pc==0: cur = i_data.
  - else: cur = max(colacc, i_data).
  - colacc <= cur on each accepted pixel.
- Row buffer: out_width entries per channel, datatype_size wide. Only pixels with col < out_width*pool_dim and row < out_width*pool_dim participate. Trailing partial columns and rows (img_width not divisible by pool_dim) are ignored: no writes, no outputs.
- When pc==pool_dim-1 on an accepted, participating pixel:
  - If pr==0: rowbuf[wc] <= cur.
  - Else: win = max(rowbuf[wc], cur).
    - pr<pool_dim-1: rowbuf[wc] <= win.
    - pr==pool_dim-1: o_data <= win and o_we <= all 1 on the next edge.
- Latency: o_we asserts exactly 1 cycle after the edge that accepted the window's last pixel. It stays high for one cycle only.
- o_data holds its last value when o_we=0.
- Output throughput: one window per pool_dim accepted pixels at most. Stalls (i_we=0) are allowed anywhere, including mid-window, with no state loss.
- o_busy: registered; 1 whenever (row,col) != (0,0) after an update.
- o_frame_done: registered; pulses on the cycle after the pixel at (img_width-1, img_width-1) is accepted. It coincides with the final o_we when img_width is divisible by pool_dim.
- Simultaneous frame end and next-frame start: back-to-back i_we across a frame boundary is legal. The first pixel of the new frame uses pr==0 and pc==0 and overwrites stale row-buffer entries.
- Reset mid-frame: partial windows are discarded and no o_we is produced. The next accepted pixel is treated as (0,0).
- No backpressure: the downstream ibuf always accepts writes.
- Arithmetic: max is an unsigned comparison, and ties select either operand. No width growth.

Test Plan:
- img_width=4, pool_dim=2, 1 channel, pixels 0..15 raster, i_we continuous -> o_we pulses 4 times with o_data 5, 7, 13, 15. The 4th pulse is coincident with o_frame_done.
- Same frame with i_we toggling 1,0,1,0... -> identical outputs (5, 7, 13, 15). Each o_we occurs 1 cycle after its accepting edge.
- img_width=5, pool_dim=2, pixels 0..24 -> outputs 6, 8, 16, 18 only. Column 4 and row 4 produce no o_we. o_frame_done pulses after pixel 24.
- input_channels=2, ch0 = pixel value, ch1 = 255-pixel value, img_width=4 -> ch0 outputs 5, 7, 13, 15 and ch1 outputs 255, 253, 247, 245. All o_we lanes are identical.
- rst asserted after 6 pixels of frame 1, then a full frame of 100+index -> no output from the aborted frame. Outputs are 105, 107, 113, 115. o_busy=0 for the cycle after reset.
- Two frames back-to-back with no gap, the second frame reversed (15..0) -> second-frame outputs 15, 13, 7, 5, with no contamination from first-frame row-buffer values.
